// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and the data memory.
//   dmem_req   : access request, held until ack or abort
//   dmem_we    : 1 = store
//   dmem_addr  : word-aligned address
//   dmem_be    : byte enables
//   dmem_wdata : lane-replicated store data
//   dmem_ack   : single-cycle completion pulse from memory
//   dmem_rdata : read word, valid with dmem_ack
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline. Issues loads/stores on the dmem bus,
// stalls upstream while an access is outstanding, formats load data and
// forwards EX/MEM fields to the MEM/WB register.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   alu_result, store_data     : address / store value from EX/MEM
//   rd_in, rt_in               : destination register ids
//   mem_read, mem_write        : load / store (both set = store)
//   mem_size, load_unsigned    : access size, zero-extend select
//   Mux_flag_*_E, banco_flag_wr_E : WB control from EX/MEM
//   dmem                       : data-memory bus (master side)
//   dato_mem                   : formatted load data (registered)
//   ALU, rd, rt, Mux_flag_*_M  : pass-through to MEM/WB
//   banco_flag_wr_M            : write enable, squashed on misalign/abort
//   mem_stall                  : hold PC, IF/ID, ID/EX, EX/MEM
//   misaligned, bus_error      : one-cycle fault pulses
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  rt_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic        Mux_flag_2_E,
  input  logic        Mux_flag_3_E,
  input  logic        banco_flag_wr_E,
  mem_access_stage_if.master dmem,
  output logic [31:0] dato_mem,
  output logic [31:0] ALU,
  output logic [4:0]  rd,
  output logic [4:0]  rt,
  output logic        Mux_flag_2_M,
  output logic        Mux_flag_3_M,
  output logic        banco_flag_wr_M,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [7:0]  cnt;
  logic        req_q, we_q;
  logic [1:0]  a;
  logic        mem_op, is_load, mis_addr, timeout, go;
  logic [31:0] wdata, shifted, fmt;
  logic [3:0]  be;

  assign a        = alu_result[1:0];
  assign mem_op   = mem_read | mem_write;
  assign is_load  = mem_read & ~mem_write;
  assign mis_addr = ((mem_size == 2'b01) & a[0]) | (mem_size[1] & (a != 2'b00));
  assign go       = (state == S_IDLE) & mem_op & ~mis_addr;
  // Ack has priority: timeout only fires on a cycle without ack.
  assign timeout  = (state == S_ACCESS) & ~dmem.dmem_ack &
                    (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_ACCESS;
      S_ACCESS: if (dmem.dmem_ack || timeout) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Store lane replication: byte/half copies fill every lane so the
  // byte enables alone select the target bytes.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wdata[i*8 +: 8] = (mem_size == 2'b00) ? store_data[7:0] :
                             (mem_size == 2'b01) ? store_data[(i%2)*8 +: 8] :
                                                   store_data[i*8 +: 8];
  end

  always_comb begin
    be = 4'b1111;
    if (mem_write) begin
      case (mem_size)
        2'b00:   be = 4'b0001 << a;
        2'b01:   be = 4'b0011 << a;
        default: be = 4'b1111;
      endcase
    end
  end

  assign shifted = dmem.dmem_rdata >> {a, 3'b000};

  always_comb begin
    case (mem_size)
      2'b00:   fmt = {{24{~load_unsigned & shifted[7]}},  shifted[7:0]};
      2'b01:   fmt = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
      default: fmt = dmem.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      dato_mem  <= 32'd0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= (state_nxt == S_ACCESS);
      we_q      <= (state_nxt == S_ACCESS) & mem_write;
      cnt       <= (state == S_ACCESS) ? cnt + 8'd1 : 8'd0;
      bus_error <= timeout;
      if ((state == S_ACCESS) && dmem.dmem_ack && is_load) dato_mem <= fmt;
      else if (timeout)                                     dato_mem <= 32'd0;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {alu_result[31:2], 2'b00};
  assign dmem.dmem_be    = be;
  assign dmem.dmem_wdata = wdata;

  assign ALU          = alu_result;
  assign rd           = rd_in;
  assign rt           = rt_in;
  assign Mux_flag_2_M = Mux_flag_2_E;
  assign Mux_flag_3_M = Mux_flag_3_E;

  // Fault pulse is held low while reset is asserted.
  assign misaligned      = rst_n & (state == S_IDLE) & mem_op & mis_addr;
  assign mem_stall       = go | (state == S_ACCESS);
  assign banco_flag_wr_M = banco_flag_wr_E &
                           ~(misaligned | ((state == S_DONE) & bus_error));

endmodule
